// File: rtl/booth_radix4_mul.sv
// Iterative radix-4 Booth multiplier for the RV32IM MUL/MULH/MULHSU/MULHU ops.
// One Booth step per cycle; each partial product is summed by a carry-lookahead adder.

module booth_cla #(
    parameter int N = 35
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum
);

    // 4-bit lookahead groups; each bit's carry is a sum-of-products of the group's g/p terms.
    always_comb begin : cla_tree
        logic [N-1:0] p;
        logic [N-1:0] g;
        logic [N-1:0] s;
        logic         grp_cin;
        logic         carry;
        logic         run_p;
        logic         c_k;
        logic         nxt;
        p       = i_a ^ i_b;
        g       = i_a & i_b;
        s       = '0;
        grp_cin = i_cin;
        carry   = 1'b0;
        run_p   = 1'b1;
        c_k     = 1'b0;
        nxt     = 1'b0;
        for (int base = 0; base < N; base += 4) begin
            for (int k = base; k < base + 4 && k < N; k++) begin
                carry = 1'b0;
                run_p = 1'b1;
                for (int t = k - 1; t >= base; t--) begin
                    carry = carry | (run_p & g[t]);
                    run_p = run_p & p[t];
                end
                c_k  = carry | (run_p & grp_cin);
                s[k] = p[k] ^ c_k;
                nxt  = g[k] | (p[k] & c_k);
            end
            grp_cin = nxt;
        end
        o_sum = s;
    end

endmodule

module booth_radix4_mul #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     rs1,
    input  logic [WIDTH-1:0]     rs2,
    input  logic                 kill,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [2*WIDTH-1:0]   product
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int CW   = $clog2(ITER);
    localparam int HW   = WIDTH + 3;
    localparam int LW   = WIDTH + 2;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_load;
    logic                  w_step;
    logic                  w_finish;

    logic [1:0]            r_op;
    logic [LW-1:0]         r_mcand;
    logic [HW-1:0]         r_acc_hi;
    logic [LW-1:0]         r_acc_lo;
    logic                  r_bm1;
    logic [CW-1:0]         r_cnt;
    logic [WIDTH-1:0]      r_result;
    logic [2*WIDTH-1:0]    r_product;

    logic                  w_sgn1;
    logic                  w_sgn2;
    logic [LW-1:0]         w_rs1_ext;
    logic [LW-1:0]         w_rs2_ext;
    logic [HW-1:0]         w_pp_mag;
    logic                  w_pp_neg;
    logic [HW-1:0]         w_cla_b;
    logic [HW-1:0]         w_sum;
    logic [HW-1:0]         w_new_hi;
    logic [LW-1:0]         w_new_lo;
    logic [2*WIDTH-1:0]    w_final_product;
    logic [WIDTH-1:0]      w_final_result;

    // rs1 is signed for MULH/MULHSU, rs2 only for MULH; two extra bits keep unsigned values positive.
    assign w_sgn1    = op[0] ^ op[1];
    assign w_sgn2    = (op == 2'b01);
    assign w_rs1_ext = {{2{w_sgn1 & rs1[WIDTH-1]}}, rs1};
    assign w_rs2_ext = {{2{w_sgn2 & rs2[WIDTH-1]}}, rs2};

    always_comb begin
        w_pp_mag = '0;
        w_pp_neg = 1'b0;
        case ({r_acc_lo[1:0], r_bm1})
            3'b001, 3'b010: w_pp_mag = {r_mcand[LW-1], r_mcand};
            3'b011:         w_pp_mag = {r_mcand, 1'b0};
            3'b100: begin
                w_pp_mag = {r_mcand, 1'b0};
                w_pp_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                w_pp_mag = {r_mcand[LW-1], r_mcand};
                w_pp_neg = 1'b1;
            end
            default: ;
        endcase
    end

    // Subtraction reuses the adder: invert the partial product and inject the +1 as carry-in.
    assign w_cla_b = w_pp_neg ? ~w_pp_mag : w_pp_mag;

    booth_cla #(.N(HW)) u_cla (
        .i_a   (r_acc_hi),
        .i_b   (w_cla_b),
        .i_cin (w_pp_neg),
        .o_sum (w_sum)
    );

    assign w_new_hi        = {{2{w_sum[HW-1]}}, w_sum[HW-1:2]};
    assign w_new_lo        = {w_sum[1:0], r_acc_lo[LW-1:2]};
    assign w_final_product = {w_new_hi[WIDTH-3:0], w_new_lo};
    assign w_final_result  = (r_op == 2'b00) ? w_final_product[WIDTH-1:0]
                                             : w_final_product[2*WIDTH-1:WIDTH];

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_CALC;
                    w_load       = 1'b1;
                end
            end
            S_CALC: begin
                if (kill)
                    w_next_state = S_IDLE;
                else if (r_cnt == CW'(ITER - 1))
                    w_next_state = S_DONE;
            end
            S_DONE: begin
                if (kill) begin
                    w_next_state = S_IDLE;
                end else if (start) begin
                    w_next_state = S_CALC;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_step   = (r_state == S_CALC) && !kill;
    assign w_finish = w_step && (r_cnt == CW'(ITER - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= 2'b00;
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_bm1     <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_product <= '0;
        end else begin
            if (w_load) begin
                r_op     <= op;
                r_mcand  <= w_rs1_ext;
                r_acc_hi <= '0;
                r_acc_lo <= w_rs2_ext;
                r_bm1    <= 1'b0;
                r_cnt    <= '0;
            end else if (w_step) begin
                r_acc_hi <= w_new_hi;
                r_acc_lo <= w_new_lo;
                r_bm1    <= r_acc_lo[1];
                r_cnt    <= r_cnt + CW'(1);
            end
            if (w_finish) begin
                r_product <= w_final_product;
                r_result  <= w_final_result;
            end
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign result  = r_result;
    assign product = r_product;

endmodule

// File: tb/tb_booth_radix4_mul.sv
// Self-checking bench for booth_radix4_mul: directed corner cases, handshake
// behaviour and randomized operands against a plain 64-bit arithmetic model.

module tb_booth_radix4_mul;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [63:0] product;

    int testsRun  = 0;
    int failCount = 0;

    booth_radix4_mul #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs1     (rs1),
        .rs2     (rs2),
        .kill    (kill),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference: extend each operand to 64 bits by the op's signedness and multiply.
    function automatic logic [63:0] refProduct(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa;
        logic [63:0] xb;
        xa = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        xb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        return xa * xb;
    endfunction

    function automatic logic [31:0] refResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = refProduct(o, a, b);
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pickOperand();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 32'h0000_0000;
        if (sel == 1) return 32'h0000_0001;
        if (sel == 2) return 32'hFFFF_FFFF;
        return $urandom;
    endfunction

    // Called at a falling edge; returns at the falling edge where done is seen (lat = -1 on timeout).
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic [63:0] prod,
                                 output int lat, output logic firstBusy);
        op        = o;
        rs1       = a;
        rs2       = b;
        start     = 1'b1;
        lat       = 0;
        firstBusy = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (lat == 1) firstBusy = busy && !done;
        end while (!done && lat < 40);
        res  = result;
        prod = product;
        if (!done) lat = -1;
    endtask

    task automatic runAndCheck(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        logic [63:0] prod;
        int          lat;
        logic        fb;
        applyStimulus(o, a, b, res, prod, lat, fb);
        checkOutput({tag, "_latency"}, 64'(lat), 64'd18);
        checkOutput({tag, "_product"}, prod, refProduct(o, a, b));
        checkOutput({tag, "_result"}, {32'b0, res}, {32'b0, refResult(o, a, b)});
    endtask

    initial begin
        logic [31:0] res;
        logic [63:0] prod;
        logic [31:0] prevRes;
        logic [63:0] prevProd;
        int          lat;
        int          cnt;
        logic        fb;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        kill  = 1'b0;
        op    = 2'b00;
        rs1   = '0;
        rs2   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {63'b0, busy}, 64'd0);
        checkOutput("reset_done", {63'b0, done}, 64'd0);
        checkOutput("reset_result", {32'b0, result}, 64'd0);
        checkOutput("reset_product", product, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a calculation must discard the operation.
        op    = 2'b00;
        rs1   = 32'd5;
        rs2   = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midcalc_busy_before", {63'b0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midcalc_reset_busy", {63'b0, busy}, 64'd0);
        checkOutput("midcalc_reset_done", {63'b0, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) cnt++;
        end
        checkOutput("aborted_no_done", 64'(cnt), 64'd0);
        checkOutput("aborted_product", product, 64'd0);

        applyStimulus(2'b00, 32'd7, 32'd3, res, prod, lat, fb);
        checkOutput("mul_7x3_latency", 64'(lat), 64'd18);
        checkOutput("mul_7x3_result", {32'b0, res}, 64'h15);

        // Signed pair issued back-to-back from the DONE cycle.
        applyStimulus(2'b00, 32'd7, 32'hFFFF_FFFD, res, prod, lat, fb);
        checkOutput("mul_signed_result", {32'b0, res}, 64'hFFFF_FFEB);
        checkOutput("mul_signed_product", prod, 64'h0000_0006_FFFF_FFEB);
        applyStimulus(2'b01, 32'd7, 32'hFFFF_FFFD, res, prod, lat, fb);
        checkOutput("b2b_no_idle", {63'b0, fb}, 64'd1);
        checkOutput("b2b_latency", 64'(lat), 64'd18);
        checkOutput("mulh_signed_product", prod, 64'hFFFF_FFFF_FFFF_FFEB);
        checkOutput("mulh_signed_result", {32'b0, res}, 64'hFFFF_FFFF);

        applyStimulus(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, prod, lat, fb);
        checkOutput("mulhu_max_result", {32'b0, res}, 64'hFFFF_FFFE);
        checkOutput("mulhu_max_product", prod, 64'hFFFF_FFFE_0000_0001);
        applyStimulus(2'b01, 32'h8000_0000, 32'h8000_0000, res, prod, lat, fb);
        checkOutput("mulh_minint_result", {32'b0, res}, 64'h4000_0000);
        applyStimulus(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, prod, lat, fb);
        checkOutput("mulhsu_product", prod, 64'hFFFF_FFFF_0000_0001);
        checkOutput("mulhsu_result", {32'b0, res}, 64'hFFFF_FFFF);
        @(negedge clk);

        // start held high while calculating, with operands changing underneath.
        op    = 2'b00;
        rs1   = 32'd6;
        rs2   = 32'd7;
        start = 1'b1;
        lat   = 0;
        cnt   = 0;
        repeat (10) begin
            @(negedge clk);
            lat++;
            if (!busy) cnt++;
            op  = 2'b01;
            rs1 = $urandom;
            rs2 = $urandom;
        end
        start = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("hold_start_busy_low_cycles", 64'(cnt), 64'd0);
        checkOutput("hold_start_latency", 64'(lat), 64'd18);
        checkOutput("hold_start_result", {32'b0, result}, 64'd42);
        @(negedge clk);

        // kill mid-calculation: back to idle, no done, outputs untouched.
        prevRes  = result;
        prevProd = product;
        op       = 2'b11;
        rs1      = 32'd1234;
        rs2      = 32'd5678;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checkOutput("kill_busy", {63'b0, busy}, 64'd0);
        cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) cnt++;
        end
        checkOutput("kill_no_done", 64'(cnt), 64'd0);
        checkOutput("kill_result_held", {32'b0, result}, {32'b0, prevRes});
        checkOutput("kill_product_held", product, prevProd);

        for (int i = 0; i < 2000; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pickOperand();
            rb  = pickOperand();
            runAndCheck("random", rop, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
